// File: rtl/uart_tx.sv
// UART 8N1/8N2 transmitter, LSB first, runtime baud divisor, one-entry holding register.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd by PARITY_ODD) after the data bits.
`timescale 1ns/1ps

module uart_tx #(
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic [11:0] baud_div,
    input  logic        txen,
    input  logic [7:0]  tx_data_i,
    output logic        txd,
    output logic        tx_ing,
    output logic        tx_rdy,
    output logic        tx_done,
    output logic        tx_drop
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t      r_state, w_state;
    logic [11:0] r_cnt, w_cnt;
    logic [11:0] r_div, w_div;
    logic [2:0]  r_bit, w_bit;
    logic [7:0]  r_shift, w_shift;
    logic [7:0]  r_hold, w_hold;
    logic        r_par, w_par;
    logic        r_txd, w_txd;
    logic        r_ing, w_ing;
    logic        r_rdy, w_rdy;
    logic        r_done, w_done;
    logic        r_drop, w_drop;

    logic [11:0] w_div_in;
    logic        w_accept;
    logic        w_xfer;
    logic        w_go;
    logic        w_bit_end;
    logic [7:0]  w_byte;

    // A pending byte moves from holding to shift register on the first clock of START.
    always_comb begin
        w_div_in  = (baud_div == 12'd0) ? 12'd1 : baud_div;
        w_accept  = txen & r_rdy;
        w_go      = w_accept | ~r_rdy;
        w_xfer    = (r_state == ST_START) && (r_cnt == r_div - 12'd1) && !r_rdy;
        w_byte    = w_xfer ? r_hold : r_shift;
        w_bit_end = (r_cnt == 12'd0);

        // NOTE: every next-state signal gets a default here so no latch is inferred.
        w_state = r_state;
        w_cnt   = w_bit_end ? r_div - 12'd1 : r_cnt - 12'd1;
        w_div   = r_div;
        w_bit   = r_bit;
        w_shift = w_byte;
        w_hold  = w_accept ? tx_data_i : r_hold;
        w_par   = w_xfer ? (^r_hold ^ PARITY_ODD) : r_par;
        w_rdy   = w_xfer ? 1'b1 : (w_accept ? 1'b0 : r_rdy);
        w_txd   = r_txd;
        w_drop  = txen & ~r_rdy;

        case (r_state)
            ST_IDLE: begin
                w_cnt = r_cnt;
                if (w_go) begin
                    w_state = ST_START;
                    w_div   = w_div_in;
                    w_cnt   = w_div_in - 12'd1;
                    w_txd   = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state = ST_DATA;
                    w_bit   = 3'd0;
                    w_txd   = w_byte[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_bit = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state = ST_PARITY;
                        w_txd   = r_par;
`else
                        w_state = ST_STOP;
                        w_txd   = 1'b1;
`endif
                    end else begin
                        w_bit   = r_bit + 3'd1;
                        w_shift = r_shift >> 1;
                        w_txd   = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state = ST_STOP;
                    w_bit   = 3'd0;
                    w_txd   = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        if (w_go) begin
                            w_state = ST_START;
                            w_div   = w_div_in;
                            w_cnt   = w_div_in - 12'd1;
                            w_txd   = 1'b0;
                        end else begin
                            w_state = ST_IDLE;
                            w_cnt   = 12'd0;
                            w_txd   = 1'b1;
                        end
                    end else begin
                        w_bit = r_bit + 3'd1;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = 12'd0;
                w_txd   = 1'b1;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        w_ing  = (w_state != ST_IDLE);
        w_done = (w_state == ST_STOP) && (w_cnt == 12'd0) && (w_bit == 3'(STOP_BITS - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only; data registers are cleared too.
    always_ff @(posedge clock_i or posedge resetn_i) begin
        if (resetn_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 12'd0;
            r_div   <= 12'd1;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_hold  <= 8'd0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_ing   <= 1'b0;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_hold  <= w_hold;
            r_par   <= w_par;
            r_txd   <= w_txd;
            r_ing   <= w_ing;
            r_rdy   <= w_rdy;
            r_done  <= w_done;
            r_drop  <= w_drop;
        end
    end

    assign txd     = r_txd;
    assign tx_ing  = r_ing;
    assign tx_rdy  = r_rdy;
    assign tx_done = r_done;
    assign tx_drop = r_drop;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus random traffic against a
// frame-level reference model (frames as scheduled bit sequences, each bit held d clocks).
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int SB    = 1;
    localparam bit P_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic        clock_i   = 1'b0;
    logic        resetn_i  = 1'b1;
    logic [11:0] baud_div  = 12'd4;
    logic        txen      = 1'b0;
    logic [7:0]  tx_data_i = 8'd0;
    logic        txd, tx_ing, tx_rdy, tx_done, tx_drop;

    always #5 clock_i = ~clock_i;

    uart_tx #(.STOP_BITS(SB), .PARITY_ODD(P_ODD)) dut (
        .clock_i   (clock_i),
        .resetn_i  (resetn_i),
        .baud_div  (baud_div),
        .txen      (txen),
        .tx_data_i (tx_data_i),
        .txd       (txd),
        .tx_ing    (tx_ing),
        .tx_rdy    (tx_rdy),
        .tx_done   (tx_done),
        .tx_drop   (tx_drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of scheduled frames plus the holding-register occupancy.
    typedef struct {
        logic [7:0] b;
        int         d;
        int         start;
    } frame_t;

    frame_t     q[$];
    int         cyc;
    bit         m_pend;
    logic [7:0] m_pb;
    int         m_clr;
    bit         m_drop;

    bit obs_txd[8192];
    bit obs_ing[8192];
    int done_q[$];
    int drop_cnt;

    function automatic int flen(input int d);
        return (9 + SB + PB) * d;
    endfunction

    function automatic bit frame_bit(input frame_t f, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return f.b[k-1];
        if (PB == 1 && k == 9) return ^f.b ^ P_ODD;
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(input int start, input int d);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = obs_txd[start + d * (i + 1) + d / 2];
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 1'b0;
        m_clr  = -1;
        m_drop = 1'b0;
    endtask

    // One clock: check outputs of this cycle, log them, then drive inputs for this cycle.
    task automatic step(input bit en, input logic [7:0] data, input logic [11:0] div);
        logic [4:0] exp_v, got_v;
        bit         act;
        int         off, dd;
        @(negedge clock_i);
        if (m_clr >= 0 && cyc > m_clr) begin
            m_pend = 1'b0;
            m_clr  = -1;
        end
        while (q.size() > 0 && cyc >= q[0].start + flen(q[0].d)) void'(q.pop_front());
        exp_v = {1'b1, 1'b0, !m_pend, 1'b0, m_drop};
        if (q.size() > 0 && cyc >= q[0].start) begin
            off      = cyc - q[0].start;
            exp_v[4] = frame_bit(q[0], off / q[0].d);
            exp_v[3] = 1'b1;
            exp_v[1] = (off == flen(q[0].d) - 1);
        end
        got_v = {txd, tx_ing, tx_rdy, tx_done, tx_drop};
        check($sformatf("cycle%0d {txd,ing,rdy,done,drop}", cyc), got_v, exp_v);
        if (cyc < 8192) begin
            obs_txd[cyc] = txd;
            obs_ing[cyc] = tx_ing;
        end
        if (tx_done) done_q.push_back(cyc);
        if (tx_drop) drop_cnt++;

        txen      = en;
        tx_data_i = data;
        baud_div  = div;
        m_drop    = en && m_pend;
        if (en && !m_pend) begin
            m_pend = 1'b1;
            m_pb   = data;
        end
        if (m_pend && m_clr < 0) begin
            act = (q.size() > 0) && (cyc >= q[0].start);
            if (!act || cyc == q[0].start + flen(q[0].d) - 1) begin
                dd = (div == 12'd0) ? 1 : int'(div);
                q.push_back('{m_pb, dd, cyc + 1});
                m_clr = cyc + 1;
            end
        end
        cyc++;
    endtask

    initial begin
        int         c0, cnt;
        logic [8:0] v;
        bit         stable;
        logic [11:0] rdiv;

        cyc = 0;
        drop_cnt = 0;
        model_reset();

        // Reset values, then a reset that abandons a frame mid-flight.
        repeat (2) @(negedge clock_i);
        check("reset_outs", {txd, tx_ing, tx_rdy, tx_done, tx_drop}, 5'b10100);
        resetn_i = 1'b0;
        step(1'b1, 8'h55, 12'd4);
        repeat (9) step(1'b0, 8'h00, 12'd4);
        #2 resetn_i = 1'b1;
        #1;
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_ing", tx_ing, 1'b0);
        check("rst_mid_rdy", tx_rdy, 1'b1);
        @(negedge clock_i);
        resetn_i = 1'b0;
        model_reset();

        // Single byte 0xA5 at 4 clocks/bit.
        done_q.delete();
        c0 = cyc;
        step(1'b1, 8'hA5, 12'd4);
        repeat (50) step(1'b0, 8'h00, 12'd4);
        stable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            v[k] = obs_txd[c0 + 1 + 4 * k];
            for (int j = 1; j < 4; j++)
                if (obs_txd[c0 + 1 + 4 * k + j] != v[k]) stable = 1'b0;
        end
        check("a5_bits", v, 9'b101001010);
        check("a5_stable", stable, 1'b1);
        check("a5_stop", obs_txd[c0 + flen(4)], 1'b1);
        check("a5_done_cnt", done_q.size(), 1);
        check("a5_done_pos", (done_q.size() > 0) ? done_q[0] - c0 : -1, flen(4));
        check("a5_ing_last", obs_ing[c0 + flen(4)], 1'b1);
        check("a5_ing_fall", obs_ing[c0 + flen(4) + 1], 1'b0);

        // Back-to-back: 0x00 then 0xFF queued during the first frame.
        done_q.delete();
        c0 = cyc;
        step(1'b1, 8'h00, 12'd3);
        repeat (4) step(1'b0, 8'h00, 12'd3);
        step(1'b1, 8'hFF, 12'd3);
        repeat (2 * flen(3) + 6) step(1'b0, 8'h00, 12'd3);
        cnt = 0;
        for (int k = 1; k <= 2 * flen(3); k++) cnt += obs_ing[c0 + k];
        check("b2b_ing_cnt", cnt, 2 * flen(3));
        check("b2b_idle_after", obs_ing[c0 + 2 * flen(3) + 1], 1'b0);
        check("b2b_done_cnt", done_q.size(), 2);
        check("b2b_done_gap", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, flen(3));
        check("b2b_byte0", decode(c0 + 1, 3), 8'h00);
        check("b2b_byte1", decode(c0 + 1 + flen(3), 3), 8'hFF);

        // Overflow: 0x11 starts, 0x22 fills holding, 0x33 arrives while full.
        done_q.delete();
        drop_cnt = 0;
        c0 = cyc;
        step(1'b1, 8'h11, 12'd8);
        step(1'b0, 8'h00, 12'd8);
        step(1'b1, 8'h22, 12'd8);
        step(1'b1, 8'h33, 12'd8);
        repeat (2 * flen(8) + 4) step(1'b0, 8'h00, 12'd8);
        check("ovf_byte0", decode(c0 + 1, 8), 8'h11);
        check("ovf_byte1", decode(c0 + 1 + flen(8), 8), 8'h22);
        check("ovf_drop_cnt", drop_cnt, 1);
        check("ovf_done_cnt", done_q.size(), 2);
        check("ovf_idle_after", obs_ing[c0 + 2 * flen(8) + 1], 1'b0);

        // baud_div = 0 behaves as 1 clock per bit.
        done_q.delete();
        c0 = cyc;
        step(1'b1, 8'h81, 12'd0);
        repeat (flen(1) + 3) step(1'b0, 8'h00, 12'd0);
        check("div0_byte", decode(c0 + 1, 1), 8'h81);
        check("div0_done_pos", (done_q.size() > 0) ? done_q[0] - c0 : -1, flen(1));
        check("div0_ing_fall", obs_ing[c0 + flen(1) + 1], 1'b0);

        // Divisor change 4 -> 6 during a frame applies to the next frame only.
        done_q.delete();
        c0 = cyc;
        step(1'b1, 8'h3C, 12'd4);
        repeat (2) step(1'b0, 8'h00, 12'd4);
        step(1'b1, 8'hC3, 12'd6);
        repeat (flen(4) + flen(6) + 4) step(1'b0, 8'h00, 12'd6);
        check("divchg_byte0", decode(c0 + 1, 4), 8'h3C);
        check("divchg_byte1", decode(c0 + 1 + flen(4), 6), 8'hC3);
        check("divchg_done0", (done_q.size() > 0) ? done_q[0] - c0 : -1, flen(4));
        check("divchg_done1", (done_q.size() > 1) ? done_q[1] - c0 : -1, flen(4) + flen(6));

`ifdef UART_TX_PARITY_EN
        // Both test bytes yield a parity bit of 1 for their respective sense.
        c0 = cyc;
        step(1'b1, P_ODD ? 8'h03 : 8'h07, 12'd4);
        repeat (flen(4) + 3) step(1'b0, 8'h00, 12'd4);
        check("parity_bit", obs_txd[c0 + 1 + 4 * 9 + 1], 1'b1);
        check("parity_len", obs_ing[c0 + 44] && !obs_ing[c0 + 45], 1'b1);
`endif

        // Random traffic with occasional divisor changes.
        rdiv = 12'd2;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) rdiv = 12'($urandom_range(0, 5));
            step($urandom_range(0, 5) == 0, 8'($urandom), rdiv);
        end
        repeat (150) step(1'b0, 8'h00, rdiv);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
